mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Single-port bus arbiter between the instruction-fetch (IF) and data-memory (MEM) stages of the MIPS32 pipeline. The arbiter serialises both stages onto one Wishbone-style memory bus, with data accesses taking priority over fetches. It raises per-stage stall requests to the pipeline controller while an access is outstanding. Each returned word is held until the consuming pipeline register (IF/ID or MEM/WB) captures it, and exception flushes drain any in-flight bus cycle.

## Interface
- No parameters; widths come from the shared defines: `InstAddrBus`/`RegBus` are 32 bits, `stall` is 6 bits.
- `clk`  in  1  Single clock, rising edge.
- `rst`  in  1  Asynchronous, active-high reset (`RstEnable`).
- `stall`  in  6  Pipeline stall vector. [1] = IF, [4] = MEM.
- `flush`  in  1  Exception flush, one-cycle pulse.
- `if_req`, `if_addr[31:0]`  in  Fetch request and word address.
- `if_rdata`  out  32  Fetched instruction.
- `if_stallreq`  out  1  Stall request for the fetch stage.
- `mem_req`, `mem_we`, `mem_sel[3:0]`, `mem_addr[31:0]`, `mem_wdata[31:0]`  in  Data request.
- `mem_rdata`  out  32  Load data.
- `mem_stallreq`  out  1  Stall request for the data stage.
- `bus_cyc_o`, `bus_stb_o`, `bus_we_o`  out  1  Bus cycle, strobe and write enable.
- `bus_sel_o[3:0]`, `bus_adr_o[31:0]`, `bus_dat_o[31:0]`  out  Bus byte select, address and write data.
- `bus_dat_i[31:0]`, `bus_ack_i`  in  Bus read data and acknowledge. `bus_ack_i` is a one-cycle pulse.

## Operation
- FSM states:
  - `IDLE`: no bus cycle in progress.
  - `MEM_BUS`: data cycle in progress.
  - `IF_BUS`: fetch cycle in progress.
  - `DRAIN`: a flushed cycle is completing; its result is discarded.
- Each port has a hold register (`*_hold_data`) and a `*_hold_valid` flag.
- A port is "pending" when `*_req` is 1 and `*_hold_valid` is 0.
- `IDLE` behaviour:
  - If `flush` = 1, start nothing.
  - Otherwise, if MEM is pending, latch mem_addr/we/sel/wdata onto the bus, assert cyc/stb, and go to `MEM_BUS`.
  - Otherwise, if IF is pending, latch if_addr with we = 0 and sel = 4'b1111, and go to `IF_BUS`.
- `MEM_BUS` / `IF_BUS` behaviour:
  - On `bus_ack_i` with `flush` = 0: capture `bus_dat_i` into the port hold register, set `hold_valid`, drop cyc/stb, and go to `IDLE`. Writes also set `hold_valid`.
  - On `bus_ack_i` with `flush` = 1: discard the data, drop cyc/stb, and go to `IDLE`.
  - On `flush` without ack: go to `DRAIN`, keeping cyc/stb asserted.
  - If `*_req` drops mid-cycle without a flush: complete the cycle and discard the data.
- `DRAIN` behaviour: on ack, drop cyc/stb and go to `IDLE`; never set `hold_valid`.
- Hold release:
  - `if_hold_valid` clears on any edge where `stall[1]` = 0 (IF/ID captured the word).
  - `mem_hold_valid` clears on any edge where `stall[4]` = 0.
  - `flush` clears both flags.
  - If a set and a clear occur on the same edge, the set wins.
- Stall request outputs (combinational):
  - `if_stallreq` = `if_req & ~if_hold_valid & ~flush`.
  - `mem_stallreq` = `mem_req & ~mem_hold_valid & ~flush`.
- Data outputs: `if_rdata` = `if_hold_data` and `mem_rdata` = `mem_hold_data`. Their value is don't-care while the matching `hold_valid` is 0.

## Timing
- Reset values: state = `IDLE`, all `bus_*_o` = 0, both hold registers = `ZeroWord`, both `hold_valid` = 0. With `if_req` = `mem_req` = 0, both stallreq outputs are 0.
- Reset during a bus cycle drops cyc/stb immediately (asynchronous). Any late ack after that is ignored in `IDLE`.
- Latency:
  - Request seen in `IDLE` at edge N: cyc/stb are high from N+1.
  - Ack sampled at edge M: `hold_valid` = 1 and stallreq = 0 from M+1.
  - Minimum fetch turnaround is 2 cycles with a zero-wait slave.
- cyc/stb are never asserted in the cycle after an ack. This gives at least one idle bus cycle between transactions.
- Bus outputs are registered. `bus_adr_o`, `bus_dat_o`, `bus_sel_o` and `bus_we_o` stay stable for the whole cycle.
- Fairness: while a data access is pending, the fetch is starved. This is acceptable because the MEM stage stalls fetch anyway.

## Structure
- `defines.v` holds `RstEnable`, `ZeroWord`, `Stop`/`NoStop`, and new stall-index constants `StallIf` = 1 and `StallMem` = 4.
- FSM state encodings are local parameters in this module.
- Sub-module `bus_port_hold` is instantiated twice, once for IF and once for MEM. It contains the hold data register and valid flag, with inputs `capture`, `release` and `clear`.
- Expected size: 150–250 lines.

## Test plan
- Fetch, zero-wait:
  - Stimulus: `if_req` = 1, `if_addr` = 0x0000_0100, ack one cycle after stb, `bus_dat_i` = 0x3C01_1234, `stall` = 0.
  - Required: `if_stallreq` is high for 2 cycles, then `if_rdata` = 0x3C01_1234 and `hold_valid` clears on the next edge.
- Simultaneous requests:
  - Stimulus: `if_req` and `mem_req` (load, `mem_addr` = 0x8000_0010) both rise in the same `IDLE` cycle.
  - Required: the first bus address is 0x8000_0010 and the second is the fetch address, with one idle bus cycle between them.
- Held result under stall:
  - Stimulus: fetch acks while `stall[1]` = 1 for 3 cycles.
  - Required: `if_rdata` is stable for those 3 cycles, `if_stallreq` = 0, and no new fetch is issued until `stall[1]` = 0.
- Flush during fetch:
  - Stimulus: `flush` pulses in `IF_BUS` with ack 2 cycles later, `bus_dat_i` = 0xDEAD_BEEF.
  - Required: the FSM passes through `DRAIN`, 0xDEAD_BEEF never appears on `if_rdata`, and cyc drops after the ack.
- Store with wait states:
  - Stimulus: `mem_we` = 1, `mem_sel` = 4'b0011, `mem_wdata` = 0x0000_ABCD, ack after 4 cycles.
  - Required: bus outputs are stable for all 4 cycles, `mem_stallreq` is high until the edge after the ack, then low.
- Reset during a data cycle:
  - Stimulus: assert `rst` mid-cycle.
  - Required: all outputs return to their reset values asynchronously, and an ack arriving during or after reset produces no `hold_valid`.

Source files
------------

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared constants for the IF/MEM single-port bus arbiter.
package mips_bus_arbiter_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;

  // Bit positions within the 6-bit pipeline stall vector.
  localparam int unsigned StallIf  = 1;
  localparam int unsigned StallMem = 4;

endpackage

// File: rtl/bus_port_hold.sv
// Per-port result register: holds a returned word until the consuming pipeline register takes it.
module bus_port_hold
  import mips_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        release_hold,
  input  logic        clear,
  input  logic [31:0] data_in,
  output logic [31:0] hold_data,
  output logic        hold_valid
);

  // Capture has priority so a word landing on a release edge is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      hold_data  <= ZeroWord;
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_data  <= data_in;
      hold_valid <= 1'b1;
    end else if (release_hold || clear) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Serialises IF fetches and MEM data accesses onto one Wishbone-style bus, MEM first.
module mips_bus_arbiter
  import mips_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stallreq,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stallreq,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMemBus = 2'd1,
    StIfBus  = 2'd2,
    StDrain  = 2'd3
  } state_e;

  state_e state_q;

  logic if_hold_valid, mem_hold_valid;
  logic if_pending, mem_pending;
  logic if_capture, mem_capture;
  logic unused_stall;

  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  assign if_pending  = if_req & ~if_hold_valid;
  assign mem_pending = mem_req & ~mem_hold_valid;

  // A requester that withdrew mid-cycle still lets the cycle finish, but gets no result.
  assign if_capture  = (state_q == StIfBus) & bus_ack_i & ~flush & if_req;
  assign mem_capture = (state_q == StMemBus) & bus_ack_i & ~flush & mem_req;

  assign if_stallreq  = if_req & ~if_hold_valid & ~flush;
  assign mem_stallreq = mem_req & ~mem_hold_valid & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q   <= StIdle;
      bus_cyc_o <= 1'b0;
      bus_stb_o <= 1'b0;
      bus_we_o  <= 1'b0;
      bus_sel_o <= 4'b0000;
      bus_adr_o <= ZeroWord;
      bus_dat_o <= ZeroWord;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!flush) begin
            if (mem_pending) begin
              bus_cyc_o <= 1'b1;
              bus_stb_o <= 1'b1;
              bus_we_o  <= mem_we;
              bus_sel_o <= mem_sel;
              bus_adr_o <= mem_addr;
              bus_dat_o <= mem_wdata;
              state_q   <= StMemBus;
            end else if (if_pending) begin
              bus_cyc_o <= 1'b1;
              bus_stb_o <= 1'b1;
              bus_we_o  <= 1'b0;
              bus_sel_o <= 4'b1111;
              bus_adr_o <= if_addr;
              state_q   <= StIfBus;
            end
          end
        end
        StMemBus, StIfBus: begin
          if (bus_ack_i) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            state_q   <= StIdle;
          end else if (flush) begin
            // The slave must still see the cycle through; its data is dropped in drain.
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (bus_ack_i) begin
            bus_cyc_o <= 1'b0;
            bus_stb_o <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  bus_port_hold u_if_hold (
    .clk          (clk),
    .rst          (rst),
    .capture      (if_capture),
    .release_hold (stall[StallIf] == NoStop),
    .clear        (flush),
    .data_in      (bus_dat_i),
    .hold_data    (if_rdata),
    .hold_valid   (if_hold_valid)
  );

  bus_port_hold u_mem_hold (
    .clk          (clk),
    .rst          (rst),
    .capture      (mem_capture),
    .release_hold (stall[StallMem] == NoStop),
    .clear        (flush),
    .data_in      (bus_dat_i),
    .hold_data    (mem_rdata),
    .hold_valid   (mem_hold_valid)
  );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: random IF/MEM traffic against a queue-based model.
`timescale 1ns/1ps
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        stall_if, stall_mem;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_stallreq;
  logic        mem_req, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_stallreq;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
  logic        bus_ack_i;

  assign stall = {1'b0, stall_mem, 2'b00, stall_if, 1'b0};

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_stallreq  (if_stallreq),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_stallreq (mem_stallreq),
    .bus_cyc_o    (bus_cyc_o),
    .bus_stb_o    (bus_stb_o),
    .bus_we_o     (bus_we_o),
    .bus_sel_o    (bus_sel_o),
    .bus_adr_o    (bus_adr_o),
    .bus_dat_o    (bus_dat_o),
    .bus_dat_i    (bus_dat_i),
    .bus_ack_i    (bus_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          is_mem;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
  } res_exp_t;

  bus_exp_t bus_q[$];
  res_exp_t if_q[$];
  res_exp_t mem_q[$];

  int errors = 0;
  int checks = 0;
  bit mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Slave memory contents: a fixed scramble of the address.
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- bus slave ----------------
  int          slave_wait = -1;
  int          fixed_wait = -1;
  bit          force_en   = 0;
  logic [31:0] force_data = 32'h0;
  bit          manual_ack = 0;

  initial begin
    bus_ack_i = 1'b0;
    bus_dat_i = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_ack_i) begin
        bus_ack_i  = 1'b0;
        slave_wait = -1;
      end else if (manual_ack) begin
        bus_ack_i  = 1'b1;
        bus_dat_i  = 32'hBAD0_0001;
        manual_ack = 0;
      end else if (bus_cyc_o && bus_stb_o) begin
        if (slave_wait < 0) slave_wait = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
        if (slave_wait == 0) begin
          bus_ack_i = 1'b1;
          bus_dat_i = force_en ? force_data : (bus_we_o ? $urandom : rd_model(bus_adr_o));
        end else begin
          slave_wait--;
        end
      end else begin
        slave_wait = -1;
      end
    end
  end

  // ---------------- bus monitor ----------------
  bit       in_cyc  = 0;
  bit       ack_prev = 0;
  bus_exp_t snap, prev_e;

  always @(negedge clk) begin : bus_mon
    bus_exp_t e;
    if (!bus_cyc_o) in_cyc = 0;
    if (mon_en) begin
      if (ack_prev) begin
        check("idle_after_ack", 32'(bus_cyc_o), 32'd0);
        check("stallreq_after_ack", 32'(prev_e.is_mem ? mem_stallreq : if_stallreq), 32'd0);
      end
      if (bus_cyc_o && bus_stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1;
          snap   = '{adr: bus_adr_o, we: bus_we_o, sel: bus_sel_o, dat: bus_dat_o, is_mem: 1'b0};
        end else begin
          check("bus_adr_stable", bus_adr_o, snap.adr);
          check("bus_dat_stable", bus_dat_o, snap.dat);
          check("bus_ctl_stable", {27'b0, bus_we_o, bus_sel_o}, {27'b0, snap.we, snap.sel});
        end
        if (bus_ack_i) begin
          if (bus_q.size() == 0) begin
            fail_now("unexpected_bus_cycle");
          end else begin
            e = bus_q.pop_front();
            check("bus_adr", bus_adr_o, e.adr);
            check("bus_we_sel", {27'b0, bus_we_o, bus_sel_o}, {27'b0, e.we, e.sel});
            if (e.we) check("bus_wdata", bus_dat_o, e.dat);
            check("stallreq_at_ack", 32'(e.is_mem ? mem_stallreq : if_stallreq), 32'd1);
            prev_e = e;
          end
        end
      end
    end
    ack_prev = mon_en && bus_cyc_o && bus_ack_i;
  end

  // ---------------- result monitors ----------------
  bit          if_shown = 0, mem_shown = 0;
  res_exp_t    if_cur, mem_cur;

  always @(negedge clk) begin : if_mon
    if (if_req && !if_stallreq && !flush && !rst) begin
      if (!if_shown) begin
        if (if_q.size() == 0) begin
          fail_now("unexpected_if_result");
          if_cur = '{rdata: 32'h0, chk: 1'b0};
        end else begin
          if_cur = if_q.pop_front();
          check("if_rdata", if_rdata, if_cur.rdata);
        end
        if_shown = 1;
      end else if (if_cur.chk) begin
        check("if_rdata_held", if_rdata, if_cur.rdata);
      end
    end else begin
      if_shown = 0;
    end
  end

  always @(negedge clk) begin : mem_mon
    if (mem_req && !mem_stallreq && !flush && !rst) begin
      if (!mem_shown) begin
        if (mem_q.size() == 0) begin
          fail_now("unexpected_mem_result");
          mem_cur = '{rdata: 32'h0, chk: 1'b0};
        end else begin
          mem_cur = mem_q.pop_front();
          if (mem_cur.chk) check("mem_rdata", mem_rdata, mem_cur.rdata);
        end
        mem_shown = 1;
      end else if (mem_cur.chk) begin
        check("mem_rdata_held", mem_rdata, mem_cur.rdata);
      end
    end else begin
      mem_shown = 0;
    end
  end

  // ---------------- stimulus ----------------
  // Each requester keeps its stage stalled until its word is back, then lets it go 1..3 edges later.
  task automatic if_txn(input logic [31:0] a);
    int t = 0;
    if_addr  = a;
    if_req   = 1'b1;
    stall_if = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (if_stallreq && t < 200);
    if (if_stallreq) fail_now("if_timeout");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    if_req   = 1'b0;
    stall_if = 1'b0;
  endtask

  task automatic mem_txn(input logic [31:0] a, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd);
    int t = 0;
    mem_addr  = a;
    mem_we    = we;
    mem_sel   = sel;
    mem_wdata = wd;
    mem_req   = 1'b1;
    stall_mem = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (mem_stallreq && t < 200);
    if (mem_stallreq) fail_now("mem_timeout");
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    mem_req   = 1'b0;
    stall_mem = 1'b0;
  endtask

  // Model: requests raised together go out data first, then fetch.
  task automatic round(input bit dm, input bit di, input logic [31:0] ma, input logic mwe,
                       input logic [3:0] msel, input logic [31:0] mwd, input logic [31:0] ia);
    if (dm) begin
      bus_q.push_back('{adr: ma, we: mwe, sel: msel, dat: mwd, is_mem: 1'b1});
      mem_q.push_back('{rdata: rd_model(ma), chk: !mwe});
    end
    if (di) begin
      bus_q.push_back('{adr: ia, we: 1'b0, sel: 4'b1111, dat: 32'h0, is_mem: 1'b0});
      if_q.push_back('{rdata: rd_model(ia), chk: 1'b1});
    end
    fork
      begin
        if (dm) mem_txn(ma, mwe, msel, mwd);
      end
      begin
        if (di) if_txn(ia);
      end
    join
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n, t;
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_sel = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    stall_if = 1'b0; stall_mem = 1'b0; mon_en = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_bus_ctl", {25'b0, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o}, 32'd0);
    check("reset_bus_adr", bus_adr_o, 32'd0);
    check("reset_bus_dat", bus_dat_o, 32'd0);
    check("reset_if_rdata", if_rdata, 32'd0);
    check("reset_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_stallreqs", {30'b0, if_stallreq, mem_stallreq}, 32'd0);
    check("idle_cyc", 32'(bus_cyc_o), 32'd0);

    // Zero-wait fetch: stallreq high for exactly two cycles, released on the next edge
    fixed_wait = 0; force_en = 1; force_data = 32'h3C01_1234;
    bus_q.push_back('{adr: 32'h0000_0100, we: 1'b0, sel: 4'b1111, dat: 32'h0, is_mem: 1'b0});
    if_q.push_back('{rdata: 32'h3C01_1234, chk: 1'b1});
    if_addr = 32'h0000_0100; if_req = 1'b1; stall_if = 1'b0;
    n = 0; t = 0;
    do begin
      @(negedge clk);
      if (if_stallreq) n++;
      t++;
    end while (if_stallreq && t < 20);
    check("fetch_stall_cycles", n, 32'd2);
    check("fetch_rdata_direct", if_rdata, 32'h3C01_1234);
    @(negedge clk);
    check("fetch_hold_released", 32'(if_stallreq), 32'd1);
    if_req = 1'b0;
    force_en = 0; fixed_wait = -1;
    @(posedge clk);
    #1;

    // Flush while a fetch is on the bus: drained, data dropped
    mon_en = 0; fixed_wait = 2; force_en = 1; force_data = 32'hDEAD_BEEF;
    if_addr = 32'h0000_0400; if_req = 1'b1; stall_if = 1'b1;
    @(posedge clk);
    #1;
    check("flush_cyc_start", 32'(bus_cyc_o), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("drain_cyc_1", 32'(bus_cyc_o), 32'd1);
    @(negedge clk);
    check("drain_cyc_2", 32'(bus_cyc_o), 32'd1);
    @(negedge clk);
    check("drain_cyc_drop", 32'(bus_cyc_o), 32'd0);
    check("drain_no_result", 32'(if_stallreq), 32'd1);
    if_req = 1'b0; stall_if = 1'b0;
    force_en = 0; fixed_wait = -1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Simultaneous load and fetch: load address goes out first
    round(1'b1, 1'b1, 32'h8000_0010, 1'b0, 4'b1111, 32'h0, 32'h0000_0104);
    // Store with wait states
    fixed_wait = 4;
    round(1'b1, 1'b0, 32'h0000_0200, 1'b1, 4'b0011, 32'h0000_ABCD, 32'h0);
    fixed_wait = -1;

    // Reset in the middle of a data cycle, then late acks
    mon_en = 0; fixed_wait = 6;
    mem_addr = 32'h0000_2000; mem_we = 1'b0; mem_sel = 4'hF; mem_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("cyc_before_reset", 32'(bus_cyc_o), 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_ctl", {25'b0, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o}, 32'd0);
    check("async_reset_adr", bus_adr_o, 32'd0);
    mem_req = 1'b0;
    #1;
    check("reset_stallreqs", {30'b0, if_stallreq, mem_stallreq}, 32'd0);
    @(negedge clk);
    manual_ack = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    manual_ack = 1;
    repeat (2) @(posedge clk);
    #2;
    mem_req = 1'b1;
    #1;
    check("no_hold_after_late_ack", 32'(mem_stallreq), 32'd1);
    mem_req = 1'b0;
    fixed_wait = -1;
    @(posedge clk);
    #1;
    mon_en = 1;

    // Random traffic
    for (int r = 0; r < 40; r++) begin
      int          kind;
      logic [31:0] ma, ia, wd;
      logic        we;
      logic [3:0]  sel;
      kind = $urandom_range(0, 2);
      ma   = $urandom & 32'hFFFF_FFFC;
      ia   = $urandom & 32'hFFFF_FFFC;
      wd   = $urandom;
      we   = 1'($urandom_range(0, 1));
      sel  = we ? 4'($urandom_range(1, 15)) : 4'b1111;
      round(kind != 1, kind != 0, ma, we, sel, wd, ia);
    end

    repeat (4) @(posedge clk);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("if_q_drained", if_q.size(), 32'd0);
    check("mem_q_drained", mem_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
